// File: rtl/cybercobra_param.sv
// cybercobra_param: parametrised single-cycle CYBERcobra core with
// loadable instruction memory, branches and IDLE/RUN/HALT control.
module cybercobra_param #(
  parameter int DATA_W     = 32,
  parameter int REG_N      = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int SW_W       = 16,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SW_W-1:0]   sw_i,
  input  logic              start_i,
  input  logic              prog_we_i,
  input  logic [AW-1:0]     prog_addr_i,
  input  logic [31:0]       prog_data_i,
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic [AW-1:0]     pc_o
);

  localparam int SH = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t state, state_nx;
  logic [AW-1:0] pc, pc_nx;

  logic [31:0] imem [IMEM_DEPTH];
  // Fixed 32 slots; slots at or above REG_N are never written and stay 0.
  logic [DATA_W-1:0] regs [32];

  logic [31:0] instr;
  logic [2:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [3:0] func;
  logic [DATA_W-1:0] a, b;
  logic [DATA_W-1:0] alu_res, wr_val;
  logic wr_en, out_en, br_taken;

  assign instr = imem[pc];
  assign op    = instr[31:29];
  assign rd    = instr[4:0];
  assign rs1   = instr[9:5];
  assign rs2   = instr[14:10];
  assign func  = instr[18:15];

  assign a = (rs1 != 5'd0 && int'(rs1) < REG_N) ? regs[rs1] : '0;
  assign b = (rs2 != 5'd0 && int'(rs2) < REG_N) ? regs[rs2] : '0;

  always_comb begin
    alu_res = '0;
    case (func)
      4'd0: alu_res = a + b;
      4'd1: alu_res = a - b;
      4'd2: alu_res = a ^ b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a & b;
      4'd5: alu_res = a << b[SH-1:0];
      4'd6: alu_res = a >> b[SH-1:0];
      4'd7: alu_res = DATA_W'($signed(a) >>> b[SH-1:0]);
      4'd8: alu_res = DATA_W'($signed(a) < $signed(b));
      4'd9: alu_res = DATA_W'(a < b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (func[2:0])
      3'd0: br_taken = (a == b);
      3'd1: br_taken = (a != b);
      3'd2: br_taken = ($signed(a) < $signed(b));
      3'd3: br_taken = ($signed(a) >= $signed(b));
      3'd4: br_taken = (a < b);
      3'd5: br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    wr_en    = 1'b0;
    wr_val   = '0;
    out_en   = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start_i) begin
          state_nx = RUN;
          pc_nx    = '0;
        end
      end
      RUN: begin
        pc_nx = pc + AW'(1);
        // Offsets are cut to AW bits, giving modulo-depth PC arithmetic.
        unique case (op)
          3'b000: begin
            wr_en  = 1'b1;
            wr_val = alu_res;
          end
          3'b001: begin
            wr_en  = 1'b1;
            wr_val = DATA_W'($signed(instr[28:10]));
          end
          3'b010: begin
            wr_en  = 1'b1;
            wr_val = DATA_W'(sw_i);
          end
          3'b011: out_en = 1'b1;
          3'b100: begin
            if (br_taken)
              pc_nx = pc + AW'($signed(instr[28:15]));
          end
          3'b101: pc_nx = pc + AW'($signed(instr[28:5]));
          3'b110: begin
            state_nx = HALT;
            pc_nx    = pc;
          end
          default: ;
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      pc          <= '0;
      out_o       <= '0;
      out_valid_o <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      out_valid_o <= out_en;
      if (out_en)
        out_o <= a;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wr_en && rd != 5'd0 && int'(rd) < REG_N) begin
      regs[rd] <= wr_val;
    end
  end

  // Program image survives reset; writable only outside RUN.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && state != RUN)
      imem[prog_addr_i] <= prog_data_i;
  end

  assign busy_o   = (state == RUN);
  assign halted_o = (state == HALT);
  assign pc_o     = pc;

endmodule

// File: doc/cybercobra_param.md
Name: cybercobra_param

Overview:
- Parametrised successor to the team's CYBERcobra primitive programmable device: single-cycle, one-instruction-per-clock core with switch input and a registered output.
- New features:
  - configurable data width, register count and instruction-memory depth;
  - runtime program loading through a write port instead of a fixed image;
  - conditional branches;
  - explicit IDLE/RUN/HALT control with start/halted handshake;
  - output-valid strobe.
- Sits between board switches/LEDs and the lab top level.

Parameters:
- DATA_W, 32, datapath and register width (8..32).
- REG_N, 32, number of registers (2..32); register 0 reads as zero.
- IMEM_DEPTH, 256, instruction words, power of two; PC width AW = clog2(IMEM_DEPTH).
- SW_W, 16, switch input width (≤ DATA_W).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- sw_i  in  SW_W  switch input, sampled by IN instruction.
- start_i  in  1  start pulse; honoured in IDLE or HALT.
- prog_we_i  in  1  instruction-memory write enable; honoured only when not RUN.
- prog_addr_i  in  AW  write address.
- prog_data_i  in  32  instruction word.
- out_o  out  DATA_W  output register.
- out_valid_o  out  1  one-cycle pulse when out_o updated.
- busy_o  out  1  high in RUN.
- halted_o  out  1  high in HALT.
- pc_o  out  AW  current program counter.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, pc=0, out_o=0, out_valid_o=0, all registers 0.
  - Instruction memory is not cleared.
- States:
  - IDLE --start_i--> RUN (pc←0).
  - RUN --HALT instr--> HALT.
  - HALT --start_i--> RUN (pc←0).
  - start_i in RUN is ignored.
- Program load:
  - In IDLE/HALT, prog_we_i=1 writes prog_data_i to imem[prog_addr_i] at the clock edge.
  - prog_we_i in RUN is ignored.
  - prog_we_i and start_i in the same cycle: the write lands and RUN starts next cycle, fetching the updated word.
- Fetch is combinational from imem[pc]; each RUN cycle executes exactly one instruction and updates pc.
- Fields:
  - op=[31:29], rd=[4:0], rs1=[9:5], rs2=[14:10], func=[18:15].
  - Register indices ≥ REG_N read 0; writes to them are dropped; writes to r0 are dropped.
- Opcodes:
  - 000 ALU: rd ← rs1 func rs2; pc+1.
  - 001 LI: rd ← sign-extend([28:10]) truncated/extended to DATA_W; pc+1.
  - 010 IN: rd ← zero-extend(sw_i); pc+1.
  - 011 OUT: out_o ← rs1, out_valid_o=1 next cycle for one cycle; pc+1.
  - 100 BR: compare rs1,rs2 by func[2:0] (0 eq, 1 ne, 2 lt signed, 3 ge signed, 4 ltu, 5 geu, 6/7 never). Taken: pc ← pc + sign-extend([28:15]); else pc+1.
  - 101 JMP: pc ← pc + sign-extend([28:5]); offset 0 is a legal self-loop and stays in RUN.
  - 110 HALT: enter HALT; pc holds.
  - 111 NOP: pc+1.
- ALU func:
  - 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu (results 0/1); 10–15 yield 0.
  - Shift amount = rs2[clog2(DATA_W)-1:0].
  - Add/sub wrap modulo 2^DATA_W; no flags.
- PC arithmetic is modulo IMEM_DEPTH: increment from IMEM_DEPTH-1 wraps to 0; negative offsets wrap.
- Register reads are combinational, so a write in cycle N is visible to the instruction in cycle N+1.
- Reset mid-RUN aborts immediately to IDLE with the reset values above; the loaded program survives.
- out_o holds its value across HALT/IDLE until the next OUT or reset.

Test Plan:
- Reset then load {LI r1,5; LI r2,7; ALU add r3,r1,r2; OUT r3; HALT}, pulse start_i → out_o=12 with out_valid_o high for exactly 1 cycle on cycle 5 after start; halted_o=1; pc_o=4.
- Countdown loop {LI r1,3; LI r2,1; OUT r1; ALU sub r1,r1,r2; BR ne r1,r0,-2; HALT} → out_o sequence 3,2,1; exactly three strobes; then HALT.
- sw_i=16'h0108: {IN r4; OUT r4; HALT} → out_o=32'h108. Change sw_i to 0 and restart → out_o=0.
- With IMEM_DEPTH=256, word 255 = NOP and word 0 = HALT, start with a JMP at word 0 replaced to jump +255 → executes 255, wraps to 0; pc_o sequence 0,255,0.
- Signed compare: LI r1,-1; LI r2,1. BR lt taken, BR ltu not taken. ALU sra of 0x80000000 by 4 → 0xF8000000. Write to r0 reads back 0. DATA_W=8 build: 250+10 → 4.
- Assert rst_i low mid-loop → outputs reset asynchronously (before the next edge). Restart runs the same program from pc 0. prog_we_i during RUN does not alter execution.
